// File: rtl/dtree_oblique_classifier.sv
// dtree_oblique_classifier
//   Oblique decision-tree classifier for spike sorting. One spike of FEATURES
//   signed samples is buffered, then a DEPTH-level binary tree is walked. Each
//   node computes sum(coeff[i]*x[i]) with one MAC per cycle and compares it
//   against the node threshold. Coefficients and thresholds are writable
//   whenever the block is idle in LOAD.
//
//   Optional build macro: DTREE_EARLY_EXIT_EN adds per-node leaf flags. A
//   node flagged as a leaf ends the walk early.
//
// Ports
//   clk, reset : clock and synchronous active-high reset
//   ready      : high in LOAD; a sample is taken on ready && in_valid
//   in_valid   : sample strobe
//   sample     : signed feature, sent in index order 0..FEATURES-1
//   cfg_ready  : config writes are honoured (same as ready)
//   cfg_we     : config write strobe
//   cfg_node   : node index (root 0, children 2n+1 / 2n+2)
//   cfg_idx    : <FEATURES coeff, ==FEATURES threshold, ==FEATURES+1 leaf flag
//   cfg_data   : signed write data
//   level      : number of decisions behind the last result
//   path       : decision bits, LSB = root decision
//   out_valid  : one-cycle result strobe
module dtree_oblique_classifier #(
  parameter  int FEATURES    = 3,
  parameter  int IN_WIDTH    = 10,
  parameter  int COEFF_WIDTH = 4,
  parameter  int DEPTH       = 2,
  localparam int NODES       = 2**DEPTH - 1,
  localparam int ACC_WIDTH   = IN_WIDTH + COEFF_WIDTH + $clog2(FEATURES) + 1,
  localparam int NW          = $clog2(NODES + 1),
  localparam int IW          = $clog2(FEATURES + 2),
  localparam int LW          = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 ready,
  input  logic                 in_valid,
  input  logic [IN_WIDTH-1:0]  sample,
  output logic                 cfg_ready,
  input  logic                 cfg_we,
  input  logic [NW-1:0]        cfg_node,
  input  logic [IW-1:0]        cfg_idx,
  input  logic [ACC_WIDTH-1:0] cfg_data,
  output logic [LW-1:0]        level,
  output logic [DEPTH-1:0]     path,
  output logic                 out_valid
);

  localparam int CW = $clog2(FEATURES + 1);
  localparam logic [CW-1:0] LAST_F = CW'(FEATURES - 1);
  localparam logic [LW-1:0] LAST_L = LW'(DEPTH - 1);

  typedef enum logic [1:0] {LOAD, EVAL, DECIDE, DONE} state_t;

  state_t                        state_r;
  logic [CW-1:0]                 cnt_r;
  logic [CW-1:0]                 idx_r;
  logic [NW-1:0]                 node_r;
  logic [LW-1:0]                 lvl_r;
  logic signed [ACC_WIDTH-1:0]   acc_r;
  logic [DEPTH-1:0]              path_work_r;
  logic                          ready_r;
  logic                          out_valid_r;
  logic [LW-1:0]                 level_r;
  logic [DEPTH-1:0]              path_r;
  logic signed [IN_WIDTH-1:0]    feat_r  [FEATURES];
  logic signed [COEFF_WIDTH-1:0] coeff_r [NODES][FEATURES];
  logic signed [ACC_WIDTH-1:0]   thr_r   [NODES];
`ifdef DTREE_EARLY_EXIT_EN
  logic [NODES-1:0]              leaf_r;
  logic                          leaf_s;
`endif

  logic signed [COEFF_WIDTH-1:0] coeff_s;
  logic signed [IN_WIDTH-1:0]    feat_s;
  logic signed [ACC_WIDTH-1:0]   thr_s;
  logic signed [ACC_WIDTH-1:0]   prod_s;
  logic                          bit_s;
  logic [DEPTH-1:0]              path_new_s;

  assign ready     = ready_r;
  assign cfg_ready = ready_r;
  assign level     = level_r;
  assign path      = path_r;
  assign out_valid = out_valid_r;

  // Select the current node/feature operands, form the MAC product and decision bit.
  always_comb begin
    coeff_s    = '0;
    feat_s     = '0;
    thr_s      = '0;
`ifdef DTREE_EARLY_EXIT_EN
    leaf_s     = 1'b0;
`endif
    for (int f = 0; f < FEATURES; f++) begin
      feat_s = (idx_r == CW'(f)) ? feat_r[f] : feat_s;
    end
    for (int n = 0; n < NODES; n++) begin
      thr_s = (node_r == NW'(n)) ? thr_r[n] : thr_s;
`ifdef DTREE_EARLY_EXIT_EN
      leaf_s = (node_r == NW'(n)) ? leaf_r[n] : leaf_s;
`endif
      for (int f = 0; f < FEATURES; f++) begin
        coeff_s = (node_r == NW'(n) && idx_r == CW'(f)) ? coeff_r[n][f] : coeff_s;
      end
    end
    // Both operands sign-extended to the accumulator width: the product always fits.
    prod_s = $signed({{(ACC_WIDTH-COEFF_WIDTH){coeff_s[COEFF_WIDTH-1]}}, coeff_s}) *
             $signed({{(ACC_WIDTH-IN_WIDTH){feat_s[IN_WIDTH-1]}}, feat_s});
    bit_s  = (acc_r >= thr_s);
    path_new_s = path_work_r;
    for (int k = 0; k < DEPTH; k++) begin
      path_new_s[k] = (lvl_r == LW'(k)) ? bit_s : path_work_r[k];
    end
  end

  // Config storage, sample buffer and the LOAD/EVAL/DECIDE/DONE sequencer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= LOAD;
      cnt_r       <= '0;
      idx_r       <= '0;
      node_r      <= '0;
      lvl_r       <= '0;
      acc_r       <= '0;
      path_work_r <= '0;
      ready_r     <= 1'b1;
      out_valid_r <= 1'b0;
      level_r     <= '0;
      path_r      <= '0;
      for (int f = 0; f < FEATURES; f++) feat_r[f] <= '0;
      for (int n = 0; n < NODES; n++) begin
        thr_r[n] <= '0;
        for (int f = 0; f < FEATURES; f++) coeff_r[n][f] <= '0;
      end
`ifdef DTREE_EARLY_EXIT_EN
      leaf_r <= '0;
`endif
    end else begin
      out_valid_r <= 1'b0;

      // Out-of-range node or index values match no entry and are dropped.
      if (cfg_we && ready_r) begin
        for (int n = 0; n < NODES; n++) begin
          if (cfg_node == NW'(n)) begin
            for (int f = 0; f < FEATURES; f++) begin
              if (cfg_idx == IW'(f)) coeff_r[n][f] <= cfg_data[COEFF_WIDTH-1:0];
            end
            if (cfg_idx == IW'(FEATURES)) thr_r[n] <= cfg_data;
`ifdef DTREE_EARLY_EXIT_EN
            if (cfg_idx == IW'(FEATURES + 1)) leaf_r[n] <= cfg_data[0];
`endif
          end
        end
      end

      case (state_r)
        LOAD: begin
          if (in_valid) begin
            for (int f = 0; f < FEATURES; f++) begin
              if (cnt_r == CW'(f)) feat_r[f] <= sample;
            end
            if (cnt_r == LAST_F) begin
              state_r     <= EVAL;
              ready_r     <= 1'b0;
              cnt_r       <= '0;
              idx_r       <= '0;
              node_r      <= '0;
              lvl_r       <= '0;
              acc_r       <= '0;
              path_work_r <= '0;
            end else begin
              cnt_r <= cnt_r + CW'(1'b1);
            end
          end else begin
            cnt_r <= cnt_r;
          end
        end
        EVAL: begin
`ifdef DTREE_EARLY_EXIT_EN
          // A leaf burns one cycle here and is resolved in DECIDE.
          if (leaf_s) begin
            idx_r   <= '0;
            state_r <= DECIDE;
          end else
`endif
          begin
            acc_r <= acc_r + prod_s;
            if (idx_r == LAST_F) begin
              idx_r   <= '0;
              state_r <= DECIDE;
            end else begin
              idx_r <= idx_r + CW'(1'b1);
            end
          end
        end
        DECIDE: begin
          acc_r <= '0;
`ifdef DTREE_EARLY_EXIT_EN
          if (leaf_s) begin
            state_r     <= DONE;
            out_valid_r <= 1'b1;
            level_r     <= lvl_r;
            path_r      <= path_work_r;
          end else
`endif
          begin
            path_work_r <= path_new_s;
            if (lvl_r == LAST_L) begin
              state_r     <= DONE;
              out_valid_r <= 1'b1;
              level_r     <= LW'(DEPTH);
              path_r      <= path_new_s;
            end else begin
              // Child index 2n+1+bit; only computed below the last level so it stays in range.
              node_r  <= NW'({node_r, 1'b0} + {{NW{1'b0}}, 1'b1} + {{NW{1'b0}}, bit_s});
              lvl_r   <= lvl_r + LW'(1'b1);
              state_r <= EVAL;
            end
          end
        end
        DONE: begin
          state_r <= LOAD;
          ready_r <= 1'b1;
        end
        default: begin
          state_r <= LOAD;
          ready_r <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dtree_oblique_classifier.sv
module tb_dtree_oblique_classifier;

  logic        clk = 1'b0;
  logic        reset;
  logic        ready;
  logic        in_valid;
  logic [9:0]  sample;
  logic        cfg_ready;
  logic        cfg_we;
  logic [1:0]  cfg_node;
  logic [2:0]  cfg_idx;
  logic [16:0] cfg_data;
  logic [1:0]  level;
  logic [1:0]  path;
  logic        out_valid;

  dtree_oblique_classifier #(.FEATURES(3), .IN_WIDTH(10), .COEFF_WIDTH(4), .DEPTH(2)) dut (
    .clk(clk), .reset(reset), .ready(ready), .in_valid(in_valid), .sample(sample),
    .cfg_ready(cfg_ready), .cfg_we(cfg_we), .cfg_node(cfg_node), .cfg_idx(cfg_idx),
    .cfg_data(cfg_data), .level(level), .path(path), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int neg_cnt  = 0;

  // Reference configuration as plain integers.
  int mc [3][3];
  int mt [3];
  int ml [3];

  typedef struct {int due; int path; int level;} exp_t;
  exp_t q[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int n = 0; n < 3; n++) begin
      mt[n] = 0;
      ml[n] = 0;
      for (int f = 0; f < 3; f++) mc[n][f] = 0;
    end
  endfunction

  function automatic void apply_cfg(input int node, input int idx, input int data);
    int c;
    if (node >= 0 && node < 3) begin
      if (idx < 3) begin
        c = data & 15;
        if (c > 7) c = c - 16;
        mc[node][idx] = c;
      end else if (idx == 3) begin
        mt[node] = data;
      end else if (idx == 4) begin
`ifdef DTREE_EARLY_EXIT_EN
        ml[node] = data & 1;
`endif
      end
    end
  endfunction

  // Walk the tree: returns path bits, decision count and edges from capture to DONE.
  function automatic void model_classify(input int x[3], output int p, output int lv, output int lat);
    int node, acc, b;
    node = 0; p = 0; lv = 0; lat = 0;
    for (int l = 0; l < 2; l++) begin
      if (ml[node] != 0) begin
        lat = lat + 2;
        return;
      end
      acc = 0;
      for (int f = 0; f < 3; f++) acc = acc + mc[node][f] * x[f];
      b = (acc >= mt[node]) ? 1 : 0;
      p = p | (b << l);
      lv = l + 1;
      lat = lat + 4;
      node = 2 * node + 1 + b;
    end
  endfunction

  task automatic cfg_write(input int node, input int idx, input int data);
    cfg_we   = 1'b1;
    cfg_node = node[1:0];
    cfg_idx  = idx[2:0];
    cfg_data = data[16:0];
    @(posedge clk); #1;
    cfg_we = 1'b0;
    apply_cfg(node, idx, data);
  endtask

  // Send one spike with random gaps; optional config write alongside feature 0.
  task automatic send(input int x0, input int x1, input int x2, input int gap_max,
                      input bit lit, input int lp, input int llv, input int llat,
                      input bit cw = 1'b0, input int cn = 0, input int ci = 0, input int cd = 0);
    int x[3];
    int p, lv, lat;
    exp_t e;
    x[0] = x0; x[1] = x1; x[2] = x2;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b0;
      repeat ($urandom_range(gap_max, 0)) begin @(posedge clk); #1; end
      check("ready_in_load", ready, 1);
      in_valid = 1'b1;
      sample   = x[i][9:0];
      if (cw && i == 0) begin
        cfg_we = 1'b1; cfg_node = cn[1:0]; cfg_idx = ci[2:0]; cfg_data = cd[16:0];
      end
      @(posedge clk); #1;
      if (cw && i == 0) begin
        cfg_we = 1'b0;
        apply_cfg(cn, ci, cd);
      end
    end
    in_valid = 1'b0;
    check("ready_low_after_capture", ready, 0);
    model_classify(x, p, lv, lat);
    if (lit) begin
      check("model_path", p, lp);
      check("model_level", lv, llv);
      check("model_latency", lat, llat);
      e.path = lp; e.level = llv; e.due = neg_cnt + 1 + llat;
    end else begin
      e.path = p; e.level = lv; e.due = neg_cnt + 1 + lat;
    end
    q.push_back(e);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (!ready && k < 60) begin @(posedge clk); #1; k++; end
    check("ready_returns", ready, 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    q.delete();
    model_reset();
  endtask

  // Result monitor: every out_valid must match the oldest expectation, on time.
  initial begin
    exp_t e;
    int cur;
    forever begin
      @(negedge clk);
      neg_cnt = neg_cnt + 1;
      cur = neg_cnt;
      if (out_valid === 1'b1) begin
        if (q.size() == 0) begin
          check("spurious_out_valid", 1, 0);
        end else begin
          e = q.pop_front();
          check("result_cycle", cur, e.due);
          check("result_path", int'(path), e.path);
          check("result_level", int'(level), e.level);
        end
      end else if (q.size() > 0 && cur > q[0].due) begin
        check("out_valid_missing", 0, 1);
        void'(q.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, actual running required done");
    $fatal(1);
  end

  initial begin
    int x0, x1, x2, thr;
    reset = 1'b1; in_valid = 1'b0; sample = '0;
    cfg_we = 1'b0; cfg_node = '0; cfg_idx = '0; cfg_data = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    check("reset_ready", ready, 1);
    check("reset_cfg_ready", cfg_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_level", level, 0);
    check("reset_path", path, 0);

    // Unconfigured tree: 0 >= 0 at both levels.
    send(5, 6, 7, 0, 1'b1, 3, 2, 8);
    check("cfg_ready_low_eval", cfg_ready, 0);
    wait_idle();
    check("path_held", path, 3);
    check("level_held", level, 2);

    // Root (1,0,0) thr 10, node1 (0,1,0) thr 3.
    cfg_write(0, 0, 1); cfg_write(0, 3, 10);
    cfg_write(1, 1, 1); cfg_write(1, 3, 3);
    send(4, 2, 9, 2, 1'b1, 0, 2, 8);
    wait_idle();

    // Node2 (0,0,-1) thr -5.
    cfg_write(2, 2, -1); cfg_write(2, 3, -5);
    send(12, 0, 3, 3, 1'b1, 3, 2, 8);
    wait_idle();
    send(12, 0, 6, 1, 1'b1, 1, 2, 8);
    // A write while busy must be dropped (model left untouched).
    cfg_we = 1'b1; cfg_node = 2'd2; cfg_idx = 3'd3; cfg_data = 17'd1000;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    wait_idle();
    // Out-of-range node and index writes are ignored.
    cfg_write(3, 0, 7);
    cfg_write(2, 5, 7);
    send(12, 0, 3, 0, 1'b1, 3, 2, 8);
    wait_idle();

    // Extreme operands: -8 * -512 * 3 = 12288 exactly at threshold.
    for (int n = 0; n < 3; n++) begin
      for (int f = 0; f < 3; f++) cfg_write(n, f, -8);
      cfg_write(n, 3, 12288);
    end
    send(-512, -512, -512, 0, 1'b1, 3, 2, 8);
    wait_idle();

    // Reset three cycles into EVAL aborts the spike.
    send(100, 200, 300, 0, 1'b0, 0, 0, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    do_reset();
    check("abort_ready", ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_level", level, 0);
    send(5, 6, 7, 0, 1'b1, 3, 2, 8);
    wait_idle();
    send(5, 6, 7, 5, 1'b1, 3, 2, 8);
    wait_idle();

    // Write coinciding with capture of feature 0 takes effect: root thr 1 -> left, node1 0>=0.
    send(0, 0, 0, 0, 1'b1, 2, 2, 8, 1'b1, 0, 3, 1);
    wait_idle();

    // Random configurations and spikes against the model.
    for (int it = 0; it < 40; it++) begin
      for (int n = 0; n < 3; n++) begin
        for (int f = 0; f < 3; f++) cfg_write(n, f, int'($urandom_range(15, 0)) - 8);
        thr = int'($urandom_range(6000, 0)) - 3000;
        cfg_write(n, 3, thr);
      end
      x0 = int'($urandom_range(1023, 0)) - 512;
      x1 = int'($urandom_range(1023, 0)) - 512;
      x2 = int'($urandom_range(1023, 0)) - 512;
      send(x0, x1, x2, 5, 1'b0, 0, 0, 0);
      wait_idle();
    end

    // Root leaf flag.
    do_reset();
    cfg_write(0, 4, 1);
`ifdef DTREE_EARLY_EXIT_EN
    send(1, 2, 3, 0, 1'b1, 0, 0, 2);
`else
    send(1, 2, 3, 0, 1'b1, 3, 2, 8);
`endif
    wait_idle();

    repeat (5) @(posedge clk);
    #1;
    check("no_pending_results", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
